// File: rtl/stallable_delay_line_if.sv
`default_nettype none
// ============================================================================
//  Module   : stallable_delay_line_if
//  Purpose  : Bundles the stream handshake, flush and delay-configuration
//             signals of stallable_delay_line into one interface.
//  Ports    : (interface signals)
//             in_valid/in_ready/in_data     upstream beat handshake
//             out_valid/out_ready/out_data  downstream beat handshake
//             flush                         discard all in-flight beats
//             delay_load/delay_sel          delay reconfiguration request
//             cur_delay/occupancy/cfg_err   status outputs
//  Modports : master (traffic source / sink side), slave (the delay line)
//  Revision : 1.0 - initial release
// ============================================================================
interface stallable_delay_line_if #(
    parameter int DATA_SIZE  = 512,
    parameter int MAX_CYCLES = 8
);
    localparam int DW = $clog2(MAX_CYCLES + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_data;
    logic                 flush;
    logic                 delay_load;
    logic [DW-1:0]        delay_sel;
    logic [DW-1:0]        cur_delay;
    logic [DW-1:0]        occupancy;
    logic                 cfg_err;

    modport master (
        output in_valid, in_data, out_ready, flush, delay_load, delay_sel,
        input  in_ready, out_valid, out_data, cur_delay, occupancy, cfg_err
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush, delay_load, delay_sel,
        output in_ready, out_valid, out_data, cur_delay, occupancy, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/stallable_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : stallable_delay_line
//  Purpose  : Fixed-latency delay line of D stages (1..MAX_CYCLES, runtime
//             selectable) with valid/ready handshake, global stall, flush
//             and a registered occupancy count.
//  Ports    : clk   - clock, rising edge
//             rstn  - synchronous active-low reset
//             bus   - stallable_delay_line_if.slave:
//                     in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//                     flush, delay_load/delay_sel, cur_delay, occupancy, cfg_err
//  Revision : 1.0 - initial release
// ============================================================================
module stallable_delay_line #(
    parameter int DATA_SIZE  = 512,
    parameter int MAX_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    stallable_delay_line_if.slave  bus
);
    localparam int            DW    = $clog2(MAX_CYCLES + 1);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_CYCLES);
    localparam logic [DW-1:0] ONE_D = DW'(1);

    // Stage storage
    logic [MAX_CYCLES-1:0] v_q, v_d;
    logic [DATA_SIZE-1:0]  d_q [MAX_CYCLES];
    logic [DATA_SIZE-1:0]  d_d [MAX_CYCLES];

    logic [DW-1:0] cur_delay_q, cur_delay_d;
    logic [DW-1:0] occupancy_q, occupancy_d;
    logic          cfg_err_q,   cfg_err_d;

    logic                 tail_v;
    logic [DATA_SIZE-1:0] tail_d;
    logic                 advance;
    logic                 accept;
    logic                 emit;
    logic [DW-1:0]        delay_clamped;

    // The output stage moves with D, so pick stage D-1 out of the array.
    always_comb begin
        tail_v = 1'b0;
        tail_d = '0;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            if (DW'(i + 1) == cur_delay_q) begin
                tail_v = v_q[i];
                tail_d = d_q[i];
            end
        end
    end

    // The whole line moves as one: it advances when the last stage is
    // empty or being consumed, otherwise every stage holds.
    assign advance       = !tail_v || bus.out_ready;
    assign bus.in_ready  = advance && !bus.flush;
    assign bus.out_valid = tail_v && !bus.flush;
    assign bus.out_data  = bus.out_valid ? tail_d : '0;

    assign accept = bus.in_valid  && bus.in_ready;
    assign emit   = bus.out_valid && bus.out_ready;

    always_comb begin
        if (bus.delay_sel == '0) begin
            delay_clamped = ONE_D;
        end else if (bus.delay_sel > MAX_D) begin
            delay_clamped = MAX_D;
        end else begin
            delay_clamped = bus.delay_sel;
        end
    end

    always_comb begin
        v_d         = v_q;
        d_d         = d_q;
        cur_delay_d = cur_delay_q;
        occupancy_d = occupancy_q;
        cfg_err_d   = 1'b0;

        if (bus.flush) begin
            v_d         = '0;
            occupancy_d = '0;
        end else if (advance) begin
            v_d[0] = bus.in_valid;
            d_d[0] = bus.in_data;
            for (int i = 1; i < MAX_CYCLES; i++) begin
                // Inactive stages are forced empty so a later increase of D
                // can never expose stale beats.
                v_d[i] = (DW'(i) < cur_delay_q) ? v_q[i-1] : 1'b0;
                d_d[i] = d_q[i-1];
            end
            if (accept && !emit) begin
                occupancy_d = occupancy_q + ONE_D;
            end else if (emit && !accept) begin
                occupancy_d = occupancy_q - ONE_D;
            end
        end

        // Changing D is only safe with nothing in flight: the only beat
        // that can be present after this edge sits in stage 0, which is
        // active for any legal D.
        if (bus.delay_load) begin
            if (occupancy_q != '0 || bus.flush) begin
                cfg_err_d = 1'b1;
            end else begin
                cur_delay_d = delay_clamped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v_q <= '0;
            for (int i = 0; i < MAX_CYCLES; i++) begin
                d_q[i] <= '0;
            end
            cur_delay_q <= MAX_D;
            occupancy_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            v_q         <= v_d;
            d_q         <= d_d;
            cur_delay_q <= cur_delay_d;
            occupancy_q <= occupancy_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign bus.cur_delay = cur_delay_q;
    assign bus.occupancy = occupancy_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_stallable_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stallable_delay_line
//  Purpose  : Self-checking bench for stallable_delay_line. A reference model
//             keeps the line as a queue of D slots and a scoreboard queue of
//             accepted payloads; a negedge monitor compares every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stallable_delay_line;
    localparam int DATA_SIZE  = 32;
    localparam int MAX_CYCLES = 8;
    localparam int DW         = $clog2(MAX_CYCLES + 1);

    typedef struct packed {
        logic                 v;
        logic [DATA_SIZE-1:0] d;
    } slot_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    stallable_delay_line_if #(.DATA_SIZE(DATA_SIZE), .MAX_CYCLES(MAX_CYCLES)) bus ();

    stallable_delay_line #(.DATA_SIZE(DATA_SIZE), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Reference model state
    slot_t                pipe [$];
    logic [DATA_SIZE-1:0] sbq  [$];
    int                   m_delay   = MAX_CYCLES;
    bit                   m_cfg_err = 1'b0;
    bit                   model_on  = 1'b0;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_emitted = 0;
    int occ_peak  = 0;

    function automatic int clamp_delay(int s);
        if (s == 0) return 1;
        if (s > MAX_CYCLES) return MAX_CYCLES;
        return s;
    endfunction

    function automatic int m_occ();
        int c = 0;
        foreach (pipe[i]) if (pipe[i].v) c++;
        return c;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the line is D slots; each advance drops the oldest slot and
    // inserts the current input at the front.
    always @(posedge clk) begin : model_step
        int    new_d;
        bit    cfg;
        bit    adv;
        slot_t head;
        if (!rstn) begin
            pipe.delete();
            for (int i = 0; i < MAX_CYCLES; i++) pipe.push_back('{v: 1'b0, d: '0});
            sbq.delete();
            m_delay   = MAX_CYCLES;
            m_cfg_err = 1'b0;
            model_on  = 1'b1;
        end else begin
            cfg   = 1'b0;
            new_d = m_delay;
            if (bus.delay_load) begin
                if (m_occ() != 0 || bus.flush) cfg = 1'b1;
                else new_d = clamp_delay(int'(bus.delay_sel));
            end
            if (bus.flush) begin
                foreach (pipe[i]) pipe[i].v = 1'b0;
                sbq.delete();
            end else begin
                adv = !pipe[$].v || bus.out_ready;
                if (adv) begin
                    void'(pipe.pop_back());
                    pipe.push_front('{v: bus.in_valid, d: bus.in_data});
                    if (bus.in_valid) sbq.push_back(bus.in_data);
                end
            end
            if (new_d != m_delay) begin
                head = pipe[0];
                pipe.delete();
                pipe.push_back(head);
                for (int i = 1; i < new_d; i++) pipe.push_back('{v: 1'b0, d: '0});
                m_delay = new_d;
            end
            m_cfg_err = cfg;
        end
    end

    // Monitor: compares outputs mid-cycle and pops the scoreboard on emit.
    always @(negedge clk) begin : monitor
        bit                   ev;
        logic [DATA_SIZE-1:0] exp_data;
        if (model_on) begin
            ev = pipe[$].v && !bus.flush;
            chk("in_ready",  64'(bus.in_ready),  64'((!pipe[$].v || bus.out_ready) && !bus.flush));
            chk("out_valid", 64'(bus.out_valid), 64'(ev));
            exp_data = '0;
            if (ev) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty: got valid output expected empty scoreboard at %0t", $time);
                end else begin
                    exp_data = sbq[0];
                end
            end
            chk("out_data",  64'(bus.out_data),  64'(exp_data));
            if (ev && bus.out_ready && sbq.size() > 0) begin
                void'(sbq.pop_front());
                n_emitted++;
            end
            chk("cur_delay", 64'(bus.cur_delay), 64'(m_delay));
            chk("occupancy", 64'(bus.occupancy), 64'(m_occ()));
            chk("cfg_err",   64'(bus.cfg_err),   64'(m_cfg_err));
            if (int'(bus.occupancy) > occ_peak) occ_peak = int'(bus.occupancy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        bus.in_valid   = 1'b0;
        bus.delay_load = 1'b0;
        bus.flush      = 1'b0;
        repeat (n) step();
    endtask

    task automatic load_delay(int sel);
        bus.delay_load = 1'b1;
        bus.delay_sel  = DW'(sel);
        step();
        bus.delay_load = 1'b0;
    endtask

    // Offer one beat and hold it until the line takes it.
    task automatic send(logic [DATA_SIZE-1:0] x);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        for (int k = 0; k < 50 && !acc; k++) begin
            #2;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no in_ready expected accept of %0h", x);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int base;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus.flush      = 1'b0;
        bus.delay_load = 1'b0;
        bus.delay_sel  = '0;

        // Reset state
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data",  64'(bus.out_data),  64'(0));
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("rst_cur_delay", 64'(bus.cur_delay), 64'(MAX_CYCLES));
        idle(2);

        // Streaming at full rate with D=8
        base = n_emitted;
        for (int i = 1; i <= 20; i++) send(DATA_SIZE'(i));
        idle(12);
        chk("stream_count", 64'(n_emitted - base), 64'(20));

        // Delay reload
        load_delay(3);
        chk("reload_3", 64'(bus.cur_delay), 64'(3));
        for (int i = 0; i < 4; i++) send(DATA_SIZE'(32'h300 + i));
        idle(6);
        load_delay(0);
        chk("reload_0", 64'(bus.cur_delay), 64'(1));
        for (int i = 0; i < 4; i++) send(DATA_SIZE'(32'h100 + i));
        idle(3);
        load_delay(15);
        chk("reload_15", 64'(bus.cur_delay), 64'(MAX_CYCLES));
        idle(2);

        // Backpressure with D=4
        load_delay(4);
        idle(1);
        occ_peak = 0;
        base = n_emitted;
        fork
            begin
                for (int i = 'hA; i <= 'hF; i++) send(DATA_SIZE'(i));
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        idle(10);
        chk("bp_count", 64'(n_emitted - base), 64'(6));
        chk("bp_peak",  64'(occ_peak),         64'(4));

        // Flush with three beats in flight
        for (int i = 0; i < 3; i++) send(DATA_SIZE'(32'hF0 + i));
        bus.flush = 1'b1;
        #2;
        chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_occ", 64'(bus.occupancy), 64'(0));
        send(DATA_SIZE'(32'hFE));
        idle(6);

        // Rejected reconfiguration with two beats in flight
        send(DATA_SIZE'(32'hC1));
        send(DATA_SIZE'(32'hC2));
        load_delay(6);
        chk("rej_cfg_err",   64'(bus.cfg_err),   64'(1));
        chk("rej_cur_delay", 64'(bus.cur_delay), 64'(4));
        step();
        chk("rej_cfg_err_end", 64'(bus.cfg_err), 64'(0));
        idle(6);

        // Reset mid-stream with five beats in flight
        load_delay(8);
        for (int i = 0; i < 5; i++) send(DATA_SIZE'(32'hD0 + i));
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("mid_rst_occ",       64'(bus.occupancy), 64'(0));
        chk("mid_rst_cur_delay", 64'(bus.cur_delay), 64'(MAX_CYCLES));
        idle(12);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid   = ($urandom_range(0, 99) < 60);
            bus.in_data    = DATA_SIZE'($urandom);
            bus.out_ready  = ($urandom_range(0, 99) < 75);
            bus.flush      = ($urandom_range(0, 99) < 2);
            bus.delay_load = ($urandom_range(0, 99) < 4);
            bus.delay_sel  = DW'($urandom_range(0, 15));
            rstn           = !($urandom_range(0, 999) < 5);
            step();
        end
        rstn          = 1'b1;
        bus.out_ready = 1'b1;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
